fifo_push_loader: RTL and testbench

- Upstream stage of the colour FIFO.
- Converts the raw, bouncing push button plus the colour switch word into exactly one FIFO write per physical press.
- Blocks writes while the FIFO reports full, and keeps write/drop statistics for the seven-segment display.
- Runs on the fast system clock, the same domain as the FIFO.

---
 rtl/fifo_push_loader_if.sv | 26 ++
 rtl/fifo_push_loader.sv | 101 ++++++++++
 tb/tb_fifo_push_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_push_loader_if.sv
// fifo_push_loader_if: button/switch inputs, FIFO write strobe and statistics of the push loader
interface fifo_push_loader_if #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 8
);
    logic             btn_push;
    logic [WIDTH-1:0] sw_data;
    logic             fifo_full;
    logic             clr_stat;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic             overflow;
    logic             busy;

    modport master (
        input  btn_push, sw_data, fifo_full, clr_stat,
        output wr_en, wr_data, push_cnt, drop_cnt, overflow, busy
    );

    modport slave (
        output btn_push, sw_data, fifo_full, clr_stat,
        input  wr_en, wr_data, push_cnt, drop_cnt, overflow, busy
    );
endinterface

// File: rtl/fifo_push_loader.sv
// fifo_push_loader: debounces the push button into one FIFO write per press and keeps write/drop statistics
module fifo_push_loader #(
    parameter int WIDTH      = 12,
    parameter int DEB_CYCLES = 1000000,
    parameter int CNT_W      = 8
) (
    input logic clk,
    input logic rst,
    fifo_push_loader_if.master bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, DEB_PRESS, WRITE, HELD, DEB_REL} state_t;

    state_t        state, state_n;
    logic [DW-1:0] cnt, cnt_n;
    logic [1:0]    sync;
    logic          btn_s;
    logic          fire;
    logic          accept;
    logic          drop;

    assign btn_s    = sync[1];
    assign accept   = fire & ~bus.fifo_full;
    assign drop     = fire & bus.fifo_full;
    assign bus.busy = state != IDLE;

    // two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or posedge rst)
        if (rst) sync <= '0;
        else     sync <= {sync[0], bus.btn_push};

    // FSM state and debounce counter registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end

    // next state: a level must persist DEB_CYCLES counts plus the deciding edge to be accepted
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        fire    = 1'b0;
        case (state)
            IDLE:
                if (btn_s) begin
                    state_n = DEB_PRESS;
                    cnt_n   = DW'(1);
                end
            DEB_PRESS:
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DW'(DEB_CYCLES)) begin
                    state_n = WRITE;
                    cnt_n   = '0;
                    fire    = 1'b1;
                end else cnt_n = cnt + 1'b1;
            WRITE:
                state_n = HELD;
            HELD:
                if (!btn_s) begin
                    state_n = DEB_REL;
                    cnt_n   = DW'(1);
                end
            DEB_REL:
                if (btn_s) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DW'(DEB_CYCLES)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else cnt_n = cnt + 1'b1;
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // write strobe/data on WRITE entry; clear beats any same-cycle counter update
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.wr_en    <= 1'b0;
            bus.wr_data  <= '0;
            bus.push_cnt <= '0;
            bus.drop_cnt <= '0;
            bus.overflow <= 1'b0;
        end else begin
            bus.wr_en    <= accept;
            if (accept) bus.wr_data <= bus.sw_data;
            bus.push_cnt <= bus.clr_stat ? '0 : bus.push_cnt + CNT_W'(accept);
            bus.drop_cnt <= bus.clr_stat ? '0 :
                            (drop && !(&bus.drop_cnt)) ? bus.drop_cnt + 1'b1 : bus.drop_cnt;
            bus.overflow <= bus.clr_stat ? 1'b0 : bus.overflow | drop;
        end
endmodule

// File: tb/tb_fifo_push_loader.sv
// tb_fifo_push_loader: directed vector table plus hand sequences for the push loader
module tb_fifo_push_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fifo_push_loader_if #(.WIDTH(12), .CNT_W(2)) bus ();

    fifo_push_loader #(.WIDTH(12), .DEB_CYCLES(4), .CNT_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int          hold;
        logic [11:0] data;
        logic        full;
        int          writes;
        logic [1:0]  push;
        logic [1:0]  drop;
        logic        ovf;
        logic [11:0] wdata;
    } vec_t;

    vec_t v[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int hold, input logic [11:0] d, input logic full, output int w);
        w = 0;
        bus.sw_data   = d;
        bus.fifo_full = full;
        bus.btn_push  = 1'b1;
        repeat (hold) begin
            step();
            w += int'(bus.wr_en);
        end
        bus.btn_push = 1'b0;
        repeat (12) begin
            step();
            w += int'(bus.wr_en);
        end
    endtask

    task automatic release_busy(input string name);
        bus.btn_push = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 6) chk({name, "_busy_before"}, 32'(bus.busy), 32'd1);
            if (i == 7) chk({name, "_busy_after"}, 32'(bus.busy), 32'd0);
        end
    endtask

    initial begin
        int w;
        int lat;
        int bw;
        v[0]  = '{3,  12'h111, 1'b0, 0, 2'd1, 2'd0, 1'b0, 12'hA5C};
        v[1]  = '{4,  12'h222, 1'b0, 0, 2'd1, 2'd0, 1'b0, 12'hA5C};
        v[2]  = '{5,  12'h3B7, 1'b0, 1, 2'd2, 2'd0, 1'b0, 12'h3B7};
        v[3]  = '{30, 12'h0F0, 1'b0, 1, 2'd3, 2'd0, 1'b0, 12'h0F0};
        v[4]  = '{10, 12'h456, 1'b0, 1, 2'd0, 2'd0, 1'b0, 12'h456};
        v[5]  = '{10, 12'h789, 1'b0, 1, 2'd1, 2'd0, 1'b0, 12'h789};
        v[6]  = '{10, 12'hDEF, 1'b1, 0, 2'd1, 2'd1, 1'b1, 12'h789};
        v[7]  = '{10, 12'hDEF, 1'b1, 0, 2'd1, 2'd2, 1'b1, 12'h789};
        v[8]  = '{10, 12'hDEF, 1'b1, 0, 2'd1, 2'd3, 1'b1, 12'h789};
        v[9]  = '{10, 12'hDEF, 1'b1, 0, 2'd1, 2'd3, 1'b1, 12'h789};
        v[10] = '{10, 12'hDEF, 1'b1, 0, 2'd1, 2'd3, 1'b1, 12'h789};

        bus.btn_push  = 1'b0;
        bus.sw_data   = '0;
        bus.fifo_full = 1'b0;
        bus.clr_stat  = 1'b0;
        repeat (3) step();
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_push", 32'(bus.push_cnt), 32'd0);
        chk("rst_drop", 32'(bus.drop_cnt), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        bus.sw_data  = 12'hA5C;
        bus.btn_push = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (i == 6) chk("clean_wr_en_e6", 32'(bus.wr_en), 32'd0);
            if (i == 7) chk("clean_wr_en_e7", 32'(bus.wr_en), 32'd1);
            if (i == 8) chk("clean_wr_en_e8", 32'(bus.wr_en), 32'd0);
        end
        chk("clean_wr_data", 32'(bus.wr_data), 32'hA5C);
        chk("clean_push", 32'(bus.push_cnt), 32'd1);
        repeat (12) step();
        release_busy("clean");
        repeat (3) step();

        for (int k = 0; k < 11; k++) begin
            press(v[k].hold, v[k].data, v[k].full, w);
            chk($sformatf("vec%0d_writes", k), 32'(w), 32'(v[k].writes));
            chk($sformatf("vec%0d_push", k), 32'(bus.push_cnt), 32'(v[k].push));
            chk($sformatf("vec%0d_drop", k), 32'(bus.drop_cnt), 32'(v[k].drop));
            chk($sformatf("vec%0d_ovf", k), 32'(bus.overflow), 32'(v[k].ovf));
            chk($sformatf("vec%0d_wdata", k), 32'(bus.wr_data), 32'(v[k].wdata));
            chk($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'd0);
        end

        bus.fifo_full = 1'b0;
        bus.clr_stat  = 1'b1;
        step();
        bus.clr_stat = 1'b0;
        chk("clr_push", 32'(bus.push_cnt), 32'd0);
        chk("clr_drop", 32'(bus.drop_cnt), 32'd0);
        chk("clr_ovf", 32'(bus.overflow), 32'd0);
        chk("clr_wdata", 32'(bus.wr_data), 32'h789);

        bus.sw_data = 12'hBCD;
        bw = 0;
        foreach (v[k]) if (k < 6) begin
            bus.btn_push = (k == 1 || k == 4) ? 1'b0 : 1'b1;
            step();
            bw += int'(bus.wr_en);
        end
        chk("bounce_burst_writes", 32'(bw), 32'd0);
        press(10, 12'hBCD, 1'b0, w);
        chk("bounce_writes", 32'(w), 32'd1);
        chk("bounce_push", 32'(bus.push_cnt), 32'd1);

        w = 0;
        bus.sw_data  = 12'h3C3;
        bus.btn_push = 1'b1;
        for (int i = 0; i < 50; i++) begin
            bus.btn_push = (i == 20 || i == 21) ? 1'b0 : 1'b1;
            step();
            w += int'(bus.wr_en);
        end
        chk("dip_writes", 32'(w), 32'd1);
        chk("dip_wdata", 32'(bus.wr_data), 32'h3C3);
        chk("dip_push", 32'(bus.push_cnt), 32'd2);
        release_busy("dip");
        repeat (3) step();

        bus.sw_data   = 12'h5A5;
        bus.fifo_full = 1'b1;
        bus.btn_push  = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i == 5) bus.fifo_full = 1'b0;
            if (i == 6) bus.clr_stat = 1'b1;
        end
        bus.clr_stat = 1'b0;
        chk("clrwin_wr_en", 32'(bus.wr_en), 32'd1);
        chk("clrwin_push", 32'(bus.push_cnt), 32'd0);
        chk("clrwin_wdata", 32'(bus.wr_data), 32'h5A5);
        press(1, 12'h5A5, 1'b0, w);
        chk("clrwin_no_second", 32'(w), 32'd0);
        repeat (3) step();

        bus.sw_data  = 12'h0AA;
        bus.btn_push = 1'b1;
        repeat (7) step();
        chk("arst_pre_wr_en", 32'(bus.wr_en), 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("arst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("arst_push", 32'(bus.push_cnt), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.wr_en && lat == 0) lat = i;
        end
        chk("arst_relatency", 32'(lat), 32'd7);
        chk("arst_push_after", 32'(bus.push_cnt), 32'd1);
        chk("arst_wdata_after", 32'(bus.wr_data), 32'h0AA);
        release_busy("arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
